// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate divider, h/v counters
// and fully registered sync, blanking, coordinate and strobe outputs.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int CLK_DIV  = 2,
    parameter int CW       = 10
) (
    input  logic          CLK,
    input  logic          RESET_N,
    input  logic          EN,
    output logic          p_tick,
    output logic          sincro_horiz,
    output logic          sincro_vert,
    output logic          video_on,
    output logic [CW-1:0] pixel_X,
    output logic [CW-1:0] pixel_Y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_FIRST = H_ACTIVE + H_FRONT;
    localparam int HS_LAST  = HS_FIRST + H_SYNC - 1;
    localparam int VS_FIRST = V_ACTIVE + V_FRONT;
    localparam int VS_LAST  = VS_FIRST + V_SYNC - 1;
    localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          tick;
    logic          hs_act;
    logic          vs_act;
    logic          vis;

    always_comb begin
        tick  = EN && (div_q == DIV_LAST);
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (EN) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        end
        if (tick) begin
            h_d = (h_q == H_LAST) ? '0 : h_q + CW'(1);
            if (h_q == H_LAST) begin
                v_d = (v_q == V_LAST) ? '0 : v_q + CW'(1);
            end
        end
    end

    // Decodes use the current counter state; outputs lag it by one CLK.
    always_comb begin
        hs_act = (int'(h_q) >= HS_FIRST) && (int'(h_q) <= HS_LAST);
        vs_act = (int'(v_q) >= VS_FIRST) && (int'(v_q) <= VS_LAST);
        vis    = (int'(h_q) < H_ACTIVE) && (int'(v_q) < V_ACTIVE);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            div_q        <= '0;
            h_q          <= '0;
            v_q          <= '0;
            p_tick       <= 1'b0;
            sincro_horiz <= ~H_POL;
            sincro_vert  <= ~V_POL;
            video_on     <= 1'b0;
            pixel_X      <= '0;
            pixel_Y      <= '0;
            line_start   <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_q          <= h_d;
            v_q          <= v_d;
            p_tick       <= tick;
            sincro_horiz <= hs_act ? H_POL : ~H_POL;
            sincro_vert  <= vs_act ? V_POL : ~V_POL;
            video_on     <= vis;
            pixel_X      <= h_q;
            pixel_Y      <= v_q;
            line_start   <= tick && (h_q == '0);
            frame_start  <= tick && (h_q == '0) && (v_q == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: two configurations driven with
// random EN gaps and a mid-run reset, checked against an arithmetic model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pt;
        logic       hs;
        logic       vs;
        logic       von;
        logic [7:0] x;
        logic [7:0] y;
        logic       ls;
        logic       fs;
    } out_t;

    localparam int A_HA = 8, A_HF = 2, A_HS = 3, A_HB = 2;
    localparam int A_VA = 5, A_VF = 1, A_VS = 2, A_VB = 2;
    localparam bit A_HP = 1'b0, A_VP = 1'b1;
    localparam int A_D  = 3;

    localparam int B_HA = 6, B_HF = 1, B_HS = 2, B_HB = 1;
    localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 2;
    localparam bit B_HP = 1'b1, B_VP = 1'b0;
    localparam int B_D  = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    logic a_pt, a_hs, a_vs, a_von, a_ls, a_fs;
    logic [7:0] a_x, a_y;
    logic b_pt, b_hs, b_vs, b_von, b_ls, b_fs;
    logic [7:0] b_x, b_y;
    out_t a_out, b_out;

    assign a_out = {a_pt, a_hs, a_vs, a_von, a_x, a_y, a_ls, a_fs};
    assign b_out = {b_pt, b_hs, b_vs, b_von, b_x, b_y, b_ls, b_fs};

    vga_timing_gen #(
        .H_ACTIVE(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_ACTIVE(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .H_POL(A_HP), .V_POL(A_VP), .CLK_DIV(A_D), .CW(8)
    ) u_a (
        .CLK(clk), .RESET_N(rst_n), .EN(en),
        .p_tick(a_pt), .sincro_horiz(a_hs), .sincro_vert(a_vs),
        .video_on(a_von), .pixel_X(a_x), .pixel_Y(a_y),
        .line_start(a_ls), .frame_start(a_fs)
    );

    vga_timing_gen #(
        .H_ACTIVE(B_HA), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_ACTIVE(B_VA), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .H_POL(B_HP), .V_POL(B_VP), .CLK_DIV(B_D), .CW(8)
    ) u_b (
        .CLK(clk), .RESET_N(rst_n), .EN(en),
        .p_tick(b_pt), .sincro_horiz(b_hs), .sincro_vert(b_vs),
        .video_on(b_von), .pixel_X(b_x), .pixel_Y(b_y),
        .line_start(b_ls), .frame_start(b_fs)
    );

    out_t qa[$];
    out_t qb[$];
    int   errs = 0;
    int   checks = 0;
    int   e = 0;

    // Position follows from the count of enabled cycles: ticks = e / D.
    function automatic out_t ref_out(
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input bit hp, input bit vp, input int d,
        input int en_cnt, input bit en_i);
        int   ht, vt, p, h, v;
        out_t o;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        p     = (en_cnt / d) % (ht * vt);
        h     = p % ht;
        v     = p / ht;
        o.pt  = en_i && ((en_cnt % d) == d - 1);
        o.x   = 8'(h);
        o.y   = 8'(v);
        o.hs  = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
        o.vs  = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
        o.von = (h < ha) && (v < va);
        o.ls  = o.pt && (h == 0);
        o.fs  = o.ls && (v == 0);
        return o;
    endfunction

    function automatic out_t rst_out(input bit hp, input bit vp);
        out_t o;
        o    = '0;
        o.hs = !hp;
        o.vs = !vp;
        return o;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s t=%0t: got pt=%b hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b, want pt=%b hs=%b vs=%b von=%b x=%0d y=%0d ls=%b fs=%b",
                name, $time, act.pt, act.hs, act.vs, act.von, act.x, act.y,
                act.ls, act.fs, exp.pt, exp.hs, exp.vs, exp.von, exp.x,
                exp.y, exp.ls, exp.fs);
        end
    endtask

    task automatic cyc(input bit en_v, input bit rst_v);
        @(negedge clk);
        en = en_v;
        if (!rst_v) begin
            rst_n = 1'b0;
            e = 0;
            #1;
            check("async_rst_a", a_out, rst_out(A_HP, A_VP));
            check("async_rst_b", b_out, rst_out(B_HP, B_VP));
            qa.push_back(rst_out(A_HP, A_VP));
            qb.push_back(rst_out(B_HP, B_VP));
        end else begin
            rst_n = 1'b1;
            qa.push_back(ref_out(A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS,
                                 A_VB, A_HP, A_VP, A_D, e, en_v));
            qb.push_back(ref_out(B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS,
                                 B_VB, B_HP, B_VP, B_D, e, en_v));
            if (en_v) e++;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0) check("dut_a", a_out, qa.pop_front());
            if (qb.size() > 0) check("dut_b", b_out, qb.pop_front());
        end
    end

    initial begin
        int hold;
        int r;
        bit en_v;
        hold = 0;
        repeat (5) cyc(1'b1, 1'b0);
        repeat (8) cyc(1'b1, 1'b1);
        for (int i = 0; i < 2500; i++) begin
            if (i >= 1500 && i < 1504) begin
                cyc(1'b1, 1'b0);
            end else begin
                r = int'($urandom_range(0, 99));
                if (hold > 0) begin
                    en_v = 1'b0;
                    hold--;
                end else if (r < 3) begin
                    en_v = 1'b0;
                    hold = int'($urandom_range(5, 40));
                end else begin
                    en_v = (r >= 10);
                end
                cyc(en_v, 1'b1);
            end
        end
        @(posedge clk);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errs++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0",
                     qa.size(), qb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
